// File: rtl/loader_pkg.sv
// Shared types and frame constants for the UART program loader.
package loader_pkg;

  // One-hot loader states
  typedef enum logic [5:0] {
    ST_IDLE  = 6'b000001,
    ST_LEN   = 6'b000010,
    ST_DATA  = 6'b000100,
    ST_CSUM  = 6'b001000,
    ST_ERROR = 6'b010000,
    ST_DONE  = 6'b100000
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         LEN_BYTES         = 2;
  localparam int         WORD_BYTES        = 4;

endpackage

// File: rtl/uart_loader_byte_packer.sv
// Packs a stream of bytes into 32-bit little-endian words (first byte lands in [7:0]).
module byte_packer
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  localparam int                IDX_W    = $clog2(WORD_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [IDX_W-1:0] r_idx;
  logic [23:0]      r_word;

  // The incoming byte completes the word on the fly, so the full word is ready
  // in the same cycle the last byte is handshaken.
  assign o_word      = {i_byte, r_word};
  assign o_word_done = i_byte_valid && (r_idx == LAST_IDX);

  // Byte index and the three most recent bytes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_byte_valid) begin
      r_idx  <= r_idx + 1'b1;
      r_word <= o_word[31:8];
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses SYNC/LEN/DATA/CSUM frames from a byte stream, writes
// packed words to memory from address 0 and releases the core on success.
//
// state    | meaning
// ST_IDLE  | hunting for the sync byte, other bytes dropped
// ST_LEN   | collecting the 16-bit little-endian word count
// ST_DATA  | packing data bytes, one memory write per word
// ST_CSUM  | comparing the checksum byte against the running XOR
// ST_ERROR | one cycle: flag the failure, back to IDLE
// ST_DONE  | load complete, core released, bytes ignored until reset
module uart_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_WIDTH     = 10,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_s_axis_tdata,
  input  logic                  i_s_axis_tvalid,
  output logic                  o_s_axis_tready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_cpu_rst,
  output logic                  o_load_done,
  output logic                  o_load_error
);

  localparam int             TMO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]    MAX_WORDS = 17'(2 ** ADDR_WIDTH);
  localparam logic           LEN_LAST  = 1'(LEN_BYTES - 1);

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_len;
  logic                  r_len_idx;
  logic [ADDR_WIDTH:0]   r_word_cnt;
  logic [7:0]            r_csum;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_mem_we, r_cpu_rst, r_load_done, r_load_error;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  logic                  w_accept, w_sync, w_tmo, w_tmo_active;
  logic                  w_len_big, w_last_word, w_word_done;
  logic [15:0]           w_len_full;
  logic [31:0]           w_word;

  assign o_s_axis_tready = 1'b1;
  assign o_mem_we        = r_mem_we;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_cpu_rst       = r_cpu_rst;
  assign o_load_done     = r_load_done;
  assign o_load_error    = r_load_error;

  assign w_accept     = i_s_axis_tvalid;
  assign w_sync       = (r_state == ST_IDLE) && w_accept && (i_s_axis_tdata == SYNC_BYTE);
  assign w_len_full   = {i_s_axis_tdata, r_len[7:0]};
  // The length bound is checked before any write, so the address can never wrap.
  assign w_len_big    = {1'b0, w_len_full} > MAX_WORDS;
  assign w_last_word  = (17'(r_word_cnt) + 17'd1) == {1'b0, r_len};
  assign w_tmo_active = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);
  assign w_tmo        = (r_tmo == TMO_LAST);

  byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_sync),
    .i_byte_valid (w_accept && (r_state == ST_DATA)),
    .i_byte       (i_s_axis_tdata),
    .o_word       (w_word),
    .o_word_done  (w_word_done)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; an accepted byte always wins over an expiring timeout
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_sync) w_state_nxt = ST_LEN;
      ST_LEN: begin
        if (w_accept) begin
          if (r_len_idx == LEN_LAST) begin
            if (w_len_big)               w_state_nxt = ST_ERROR;
            else if (w_len_full == 16'd0) w_state_nxt = ST_CSUM;
            else                          w_state_nxt = ST_DATA;
          end
        end else if (w_tmo) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_DATA: begin
        if (w_accept) begin
          if (w_word_done && w_last_word) w_state_nxt = ST_CSUM;
        end else if (w_tmo) begin
          w_state_nxt = ST_ERROR;
        end
      end
      ST_CSUM: begin
        if (w_accept)   w_state_nxt = (i_s_axis_tdata == r_csum) ? ST_DONE : ST_ERROR;
        else if (w_tmo) w_state_nxt = ST_ERROR;
      end
      ST_ERROR: w_state_nxt = ST_IDLE;
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: length capture, checksum, word counter and memory write port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len       <= '0;
      r_len_idx   <= 1'b0;
      r_word_cnt  <= '0;
      r_csum      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_sync) begin
        r_csum     <= '0;
        r_len_idx  <= 1'b0;
        r_word_cnt <= '0;
      end
      if ((r_state == ST_LEN) && w_accept) begin
        r_csum    <= r_csum ^ i_s_axis_tdata;
        r_len_idx <= ~r_len_idx;
        if (r_len_idx == LEN_LAST) r_len[15:8] <= i_s_axis_tdata;
        else                       r_len[7:0]  <= i_s_axis_tdata;
      end
      if ((r_state == ST_DATA) && w_accept) begin
        r_csum <= r_csum ^ i_s_axis_tdata;
        if (w_word_done) begin
          r_mem_we    <= 1'b1;
          r_mem_wdata <= w_word;
          r_mem_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
          r_word_cnt  <= r_word_cnt + 1'b1;
        end
      end
    end
  end

  // Sticky status flags and core reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cpu_rst    <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      if (w_sync) r_load_error <= 1'b0;
      if (r_state == ST_ERROR) r_load_error <= 1'b1;
      if ((r_state == ST_CSUM) && w_accept && (i_s_axis_tdata == r_csum)) begin
        r_load_done <= 1'b1;
        r_cpu_rst   <= 1'b0;
      end
    end
  end

  // Inter-byte timeout, only running while a frame is open
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                     r_tmo <= '0;
    else if (w_accept || !w_tmo_active) r_tmo <= '0;
    else                              r_tmo <= r_tmo + 1'b1;
  end

endmodule

// File: tb/tb_uart_loader.sv
// Randomized frame-level bench for uart_loader with a write scoreboard.
module tb_uart_loader;

  localparam int AW  = 4;
  localparam int TMO = 64;
  localparam int MAXW = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    tdata = 8'h00;
  logic          tvalid = 1'b0;
  logic          tready, mem_we, cpu_rst, load_done, load_error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  uart_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_s_axis_tdata  (tdata),
    .i_s_axis_tvalid (tvalid),
    .o_s_axis_tready (tready),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .o_cpu_rst       (cpu_rst),
    .o_load_done     (load_done),
    .o_load_error    (load_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;

  wr_t        exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  bit         m_done = 0;
  bit         m_err = 0;
  logic [7:0] pay [0:(4*MAXW)+3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e.addr));
        chk("write_data", mem_wdata, e.data);
        chk("write_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Inputs change 1 time unit after a rising edge; tasks keep that invariant.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    idle($urandom_range(0, 2));
    tdata  = b;
    tvalid = 1'b1;
    @(posedge clk); #1;
    tvalid   = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic check_reset_values();
    chk("rst_tready", 32'(tready), 1);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_load_done", 32'(load_done), 0);
    chk("rst_load_error", 32'(load_error), 0);
  endtask

  // Asserts reset off the clock edge and checks the outputs before any edge.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    chk("rst_queue_empty", 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    m_done = 0;
    m_err  = 0;
  endtask

  task automatic settle_check(input string tag);
    idle(4);
    chk({tag, "_done"}, 32'(load_done), 32'(m_done));
    chk({tag, "_error"}, 32'(load_error), 32'(m_err));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!m_done));
    chk({tag, "_tready"}, 32'(tready), 1);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < 4 * len; i++) pay[i] = 8'($urandom);
  endtask

  task automatic send_noise(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h00;
      send_byte(b);
    end
  endtask

  // Sends one frame using pay[]; stall_at >= 0 stops sending after that many
  // data bytes and waits past the timeout.
  task automatic send_frame(input int len, input bit corrupt, input int stall_at, input string tag);
    logic [7:0] cs, lo, hi;
    wr_t        e;
    lo = len[7:0];
    hi = len[15:8];
    send_byte(8'hA5);
    if (!m_done) m_err = 0;
    send_byte(lo);
    send_byte(hi);
    cs = lo ^ hi;
    if (len > MAXW) begin
      if (!m_done) m_err = 1;
      settle_check(tag);
      return;
    end
    for (int i = 0; i <= 4 * len; i++) begin
      if (i == stall_at) begin
        idle(TMO + 6);
        if (!m_done) m_err = 1;
        settle_check(tag);
        return;
      end
      if (i == 4 * len) break;
      send_byte(pay[i]);
      cs = cs ^ pay[i];
      if ((i % 4 == 3) && !m_done) begin
        e.addr = AW'(i / 4);
        e.data = {pay[i], pay[i-1], pay[i-2], pay[i-3]};
        e.cyc  = last_cyc;
        exp_q.push_back(e);
      end
    end
    send_byte(corrupt ? (cs ^ 8'h01) : cs);
    if (!m_done) begin
      if (corrupt) m_err = 1;
      else         m_done = 1;
    end
    settle_check(tag);
  endtask

  task automatic load_nominal();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    pay[4] = 8'h55; pay[5] = 8'h66; pay[6] = 8'h77; pay[7] = 8'h88;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, stall;
    bit bad;
    #1;
    do_reset();

    // Noise, then the reference frame with a bad checksum, then the good frame
    send_noise(0);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
    idle(3);
    chk("noise_no_error", 32'(load_error), 0);
    load_nominal();
    send_frame(2, 1'b1, -1, "bad_csum");
    load_nominal();
    send_frame(2, 1'b0, -1, "nominal");

    // Frames after completion must be ignored
    fill_random(3);
    send_frame(3, 1'b0, -1, "post_done");

    // Reset in the middle of the data phase
    send_byte(8'h00);
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    do_reset();

    // Empty frame
    send_frame(0, 1'b0, -1, "empty");

    // Oversize, then the largest legal frame
    do_reset();
    send_frame(MAXW + 1, 1'b0, -1, "oversize");
    fill_random(MAXW);
    send_frame(MAXW, 1'b0, -1, "max_len");

    // Timeout mid-data
    do_reset();
    load_nominal();
    send_frame(1, 1'b0, 2, "timeout");

    // Randomized frames
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 3) == 0) send_noise($urandom_range(1, 3));
      len   = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW + 1, MAXW + 4)
                                          : $urandom_range(0, MAXW);
      bad   = ($urandom_range(0, 2) == 0);
      stall = -1;
      if (len > 0 && len <= MAXW && $urandom_range(0, 5) == 0)
        stall = $urandom_range(0, 4 * len);
      fill_random(len);
      send_frame(len, bad, stall, "random");
      if (m_done) do_reset();
    end

    idle(4);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Boot-time program loader sitting between uart_rx (AXI-Stream byte source) and the instruction/data memory write port.
- Parses a framed byte stream, packs bytes into 32-bit little-endian words, writes them to consecutive word addresses from 0, and verifies a checksum.
- Holds the CPU core in reset until a frame loads successfully; afterwards it releases the core and discards further bytes.

Parameters:
- ADDR_WIDTH, 10, memory word-address width; maximum load size is 2**ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, maximum Clk cycles allowed between accepted bytes inside a frame.

Ports:
- Clk  in  1  system clock.
- Rst_n  in  1  asynchronous reset, active-low.
- S_axis_tdata  in  8  received byte from uart_rx.
- S_axis_tvalid  in  1  byte valid.
- S_axis_tready  out  1  loader accepts byte.
- Mem_we  out  1  one-cycle memory write strobe.
- Mem_addr  out  ADDR_WIDTH  word address.
- Mem_wdata  out  32  word to write.
- Cpu_rst  out  1  core reset, active-high.
- Load_done  out  1  sticky: frame loaded and checksum OK.
- Load_error  out  1  sticky until next sync byte: last frame failed.

Behaviour:
- Reset: one clock; Rst_n is asynchronous, active-low. All state clears immediately when Rst_n=0, regardless of Clk.
  - Reset values: S_axis_tready=1, Mem_we=0, Mem_addr=0, Mem_wdata=0, Cpu_rst=1, Load_done=0, Load_error=0.
  - State goes to ST_IDLE; counters and checksum go to 0.
  - Reset mid-frame abandons the frame; words already written are not rolled back.
- Handshake:
  - S_axis_tready=1 in every state; no backpressure is applied.
  - A byte is accepted on a Clk edge where tvalid & tready.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 4*LEN data bytes (LSB first per word), then CSUM.
  - CSUM = XOR of LEN_LO, LEN_HI and all data bytes.
- State machine (one-hot enum):
  - ST_IDLE: an accepted byte equal to SYNC_BYTE clears Load_error, checksum, byte counter and word address, then goes to ST_LEN. Any other byte is dropped.
  - ST_LEN: accepts 2 bytes into the 16-bit LEN (little-endian).
    - After LEN_HI: if LEN > 2**ADDR_WIDTH, go to ST_ERROR.
    - Else if LEN == 0, go to ST_CSUM.
    - Else go to ST_DATA.
  - ST_DATA: 2-bit byte index shifts bytes into the word.
    - On acceptance of byte index 3, Mem_we=1 on the following cycle, with Mem_wdata = the assembled word and Mem_addr = the current word address.
    - The word address increments after the write.
    - After word LEN-1 is written, go to ST_CSUM.
    - A byte arriving in the same cycle as Mem_we is accepted normally.
  - ST_CSUM: one accepted byte.
    - If equal to the running XOR: go to ST_DONE, set Load_done=1, Cpu_rst=0 (both registered, visible the cycle after acceptance).
    - Else go to ST_ERROR.
  - ST_ERROR: single cycle. Sets Load_error=1, keeps Cpu_rst=1, then returns to ST_IDLE.
  - ST_DONE: terminal until reset. All bytes accepted and dropped; Mem_we stays 0.
- Timeout:
  - The counter clears on every accepted byte and counts in ST_LEN, ST_DATA and ST_CSUM.
  - Reaching TIMEOUT_CYCLES-1 forces ST_ERROR.
  - Does not count in ST_IDLE, ST_DONE or ST_ERROR.
- Simultaneous events: a timeout expiring on the same cycle a byte is accepted resolves in favour of the byte.
- Widths and arithmetic:
  - The word counter is ADDR_WIDTH+1 bits so the LEN = 2**ADDR_WIDTH boundary is legal.
  - Mem_addr never wraps, because the length check precedes any write.
- Write latency: exactly 1 cycle from the 4th-byte handshake to Mem_we.

Decomposition:
- loader_pkg holds:
  - the state enum typedef;
  - the default SYNC_BYTE constant;
  - the frame field constants (LEN_BYTES=2, WORD_BYTES=4).
- One sub-module, byte_packer: shifts 8-bit bytes into a 32-bit LE word and flags word-complete. Inputs: Clk, Rst_n, clear, byte_valid, byte.
- The FSM, address counter, checksum and timeout remain in uart_loader.

Test Plan:
- Nominal load: A5 02 00 11 22 33 44 55 66 77 88 8A -> writes addr0=0x44332211 and addr1=0x88776655, each Mem_we one cycle after the 4th byte; then Load_done=1, Cpu_rst=0, Load_error=0.
- Bad checksum: same frame with CSUM=8B -> Load_error=1, Cpu_rst=1, Load_done=0. Resending the correct frame -> Load_error clears on A5, Load_done=1.
- Preamble noise: 00 FF 5A before the frame -> no writes, no error; the frame then loads normally.
- Empty and oversize: A5 00 00 00 -> Load_done=1 with no Mem_we. With ADDR_WIDTH=4, A5 11 00 -> Load_error=1 right after LEN_HI, no writes.
- Timeout: TIMEOUT_CYCLES=64; A5 01 00 11 22, then idle 64 cycles -> Load_error=1, state returns to IDLE, no write issued.
- Reset mid-frame and post-done: Rst_n low during the data phase -> outputs return to reset values asynchronously. After a successful load, a second A5 frame -> no Mem_we, Cpu_rst stays 0.
